// File: rtl/pgm_loader_if.sv
// Byte-stream input and RAM programming port of the program loader.
// slave: the loader side; master: the byte source / RAM / CPU side.
interface pgm_loader_if;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic        pgm;
   logic [15:0] pgm_addr;
   logic [15:0] pgm_data;
   logic        pg_wr;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        err;

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, pgm, pgm_addr, pgm_data, pg_wr, cpu_hold, busy, done, err
   );

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, pgm, pgm_addr, pgm_data, pg_wr, cpu_hold, busy, done, err
   );
endinterface

// File: rtl/pgm_loader.sv
// Parses SYNC, CNT_HI, CNT_LO, CNT x (hi,lo) words from a byte stream and writes
// them to RAM addresses 0..CNT-1 through a level-stretched pg_wr strobe.
module pgm_loader #(
   parameter int         MEM_SIZE  = 255,
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         STROBE_HI = 4,
   parameter int         STROBE_LO = 4
) (
   input logic         clk,
   input logic         rst,
   pgm_loader_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WR_HI, WR_LO, DONE
   } state_t;

   state_t      state;
   logic [15:0] cnt;
   logic [7:0]  tmr;
   logic        xfer;
   logic [15:0] len_next;
   logic [15:0] addr_next;

   assign xfer      = bus.rx_valid & bus.rx_ready;
   assign len_next  = {cnt[15:8], bus.rx_data};
   assign addr_next = bus.pgm_addr + 16'd1;

   // rx_ready is registered, so it is updated on every edge that enters or
   // leaves a byte-consuming state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         tmr          <= '0;
         bus.rx_ready <= 1'b0;
         bus.pgm      <= 1'b0;
         bus.pgm_addr <= '0;
         bus.pgm_data <= '0;
         bus.pg_wr    <= 1'b0;
         bus.cpu_hold <= 1'b0;
         bus.busy     <= 1'b0;
         bus.done     <= 1'b0;
         bus.err      <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         case (state)
            IDLE: begin
               bus.rx_ready <= 1'b1;
               if (xfer && bus.rx_data == SYNC_BYTE) begin
                  state        <= LEN_HI;
                  bus.pgm      <= 1'b1;
                  bus.cpu_hold <= 1'b1;
                  bus.busy     <= 1'b1;
               end
            end
            LEN_HI: begin
               if (xfer) begin
                  cnt[15:8] <= bus.rx_data;
                  state     <= LEN_LO;
               end
            end
            LEN_LO: begin
               if (xfer) begin
                  if (len_next == 16'd0 || len_next > 16'(MEM_SIZE)) begin
                     bus.err      <= 1'b1;
                     bus.pgm      <= 1'b0;
                     bus.cpu_hold <= 1'b0;
                     bus.busy     <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     cnt[7:0]     <= bus.rx_data;
                     bus.pgm_addr <= '0;
                     state        <= DAT_HI;
                  end
               end
            end
            DAT_HI: begin
               if (xfer) begin
                  bus.pgm_data[15:8] <= bus.rx_data;
                  state              <= DAT_LO;
               end
            end
            DAT_LO: begin
               if (xfer) begin
                  bus.pgm_data[7:0] <= bus.rx_data;
                  bus.pg_wr         <= 1'b1;
                  bus.rx_ready      <= 1'b0;
                  tmr               <= '0;
                  state             <= WR_HI;
               end
            end
            WR_HI: begin
               if (tmr == 8'(STROBE_HI - 1)) begin
                  bus.pg_wr <= 1'b0;
                  tmr       <= '0;
                  state     <= WR_LO;
               end else begin
                  tmr <= tmr + 8'd1;
               end
            end
            WR_LO: begin
               // Address only moves once the RAM has long since committed.
               if (tmr == 8'(STROBE_LO - 1)) begin
                  tmr          <= '0;
                  bus.pgm_addr <= addr_next;
                  if (addr_next == cnt) begin
                     state <= DONE;
                  end else begin
                     state        <= DAT_HI;
                     bus.rx_ready <= 1'b1;
                  end
               end else begin
                  tmr <= tmr + 8'd1;
               end
            end
            DONE: begin
               bus.done     <= 1'b1;
               bus.pgm      <= 1'b0;
               bus.cpu_hold <= 1'b0;
               bus.busy     <= 1'b0;
               bus.rx_ready <= 1'b1;
               state        <= IDLE;
            end
            default: begin
               state        <= IDLE;
               bus.rx_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pgm_loader.sv
// Randomized frame bench for pgm_loader with a RAM-side commit monitor and
// a frame-level expected-write model.
module tb_pgm_loader;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pgm_loader_if bus ();

   pgm_loader dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // RAM side: 3-stage edge detector, write committed while pgm is high
   logic [2:0]  det = 3'b000;
   logic [31:0] log_q[$];
   logic        prev_wr = 1'b0;
   logic        seen_fall = 1'b0;
   int rises = 0, dones = 0, errs = 0, viol = 0;
   int hi_run = 0, lo_run = 0, fall_age = 100;
   int hi_min = 1000, hi_max = 0, lo_min = 1000;

   always @(posedge clk) begin
      det     <= {det[1:0], bus.pg_wr};
      prev_wr <= bus.pg_wr;
      if (det[1] && !det[2] && bus.pgm) log_q.push_back({bus.pgm_addr, bus.pgm_data});
      if (bus.done) dones <= dones + 1;
      if (bus.err) errs <= errs + 1;
      if (bus.pg_wr && !prev_wr) rises <= rises + 1;
      if (rst) begin
         hi_run    <= 0;
         lo_run    <= 0;
         seen_fall <= 1'b0;
         fall_age  <= 100;
      end else if (bus.pg_wr) begin
         hi_run   <= hi_run + 1;
         fall_age <= 0;
         lo_run   <= 0;
         if (bus.rx_ready) viol <= viol + 1;
         if (!prev_wr && seen_fall && lo_run < lo_min) lo_min <= lo_run;
      end else begin
         lo_run <= lo_run + 1;
         if (fall_age < 100) fall_age <= fall_age + 1;
         if (bus.rx_ready && fall_age < 4) viol <= viol + 1;
         if (prev_wr) begin
            seen_fall <= 1'b1;
            hi_run    <= 0;
            if (hi_run < hi_min) hi_min <= hi_run;
            if (hi_run > hi_max) hi_max <= hi_run;
         end else if (!bus.pgm) begin
            seen_fall <= 1'b0;
         end
      end
   end

   int tests = 0, fails = 0;
   logic [15:0] img[$];

   task automatic chk(input string tag, input longint obs, input longint exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input bit hold);
      int n = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      while (!bus.rx_ready && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 2000) begin
         tests++;
         fails++;
         $error("FAIL send_timeout: got rx_ready=0, expected 1 within 2000 cycles");
      end
      @(posedge clk);
      @(negedge clk);
      if (!hold) begin
         bus.rx_valid = 1'b0;
         bus.rx_data  = 8'($urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy && n < 30000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 30000) begin
         tests++;
         fails++;
         $error("FAIL idle_timeout: got busy=1, expected 0 within 30000 cycles");
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic check_writes(input string tag, input int base, input int n);
      int bad = 0;
      chk({tag, " writes"}, log_q.size() - base, n);
      for (int i = 0; i < n && base + i < log_q.size(); i++)
         if (log_q[base + i] !== {16'(i), img[i]}) bad++;
      chk({tag, " data"}, bad, 0);
   endtask

   // Model: a legal count writes img[0..cnt-1] to addresses 0..cnt-1 with one
   // strobe per word and one done; an illegal count gives one err and nothing else.
   task automatic run_frame(input logic [15:0] cnt, input bit hold, input string tag);
      int b_log  = log_q.size();
      int b_rise = rises;
      int b_done = dones;
      int b_err  = errs;
      bit legal  = (cnt != 16'd0) && (cnt <= 16'd255);
      send(8'hA5, hold);
      send(cnt[15:8], hold);
      send(cnt[7:0], hold);
      if (legal)
         for (int i = 0; i < int'(cnt); i++) begin
            send(img[i][15:8], hold);
            send(img[i][7:0], hold);
         end
      bus.rx_valid = 1'b0;
      wait_idle();
      check_writes(tag, b_log, legal ? int'(cnt) : 0);
      chk({tag, " rises"}, rises - b_rise, legal ? int'(cnt) : 0);
      chk({tag, " done"}, dones - b_done, legal ? 1 : 0);
      chk({tag, " err"}, errs - b_err, legal ? 0 : 1);
      chk({tag, " pgm/hold/busy/wr"}, {bus.pgm, bus.cpu_hold, bus.busy, bus.pg_wr}, 0);
   endtask

   task automatic rand_img(input int n);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
   endtask

   initial begin
      int b_log, b_done;
      rst          = 1'b1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      repeat (3) @(negedge clk);
      chk("reset outputs", {bus.pgm, bus.pg_wr, bus.cpu_hold, bus.busy, bus.done, bus.err,
                            bus.rx_ready, bus.pgm_addr, bus.pgm_data}, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle rx_ready", bus.rx_ready, 1);

      img = '{16'h1234, 16'hABCD};
      run_frame(16'd2, 1'b0, "t1");

      send(8'h00, 1'b0);
      send(8'hFF, 1'b0);
      img = '{16'hBEEF};
      run_frame(16'd1, 1'b0, "t2");

      run_frame(16'd0, 1'b0, "cnt0");
      run_frame(16'd256, 1'b0, "cnt256");

      img = '{16'hA5A5, 16'h00A5, 16'hA500};
      run_frame(16'd3, 1'b0, "sync_in_data");

      rand_img(10);
      run_frame(16'd10, 1'b1, "t4");
      chk("no rx_ready in write", viol, 0);
      chk("strobe hi min", hi_min, 4);
      chk("strobe hi max", hi_max, 4);
      chk("strobe lo >= 4", lo_min >= 4, 1);

      for (int k = 0; k < 4; k++) begin
         int n = $urandom_range(1, 12);
         rand_img(n);
         run_frame(16'(n), 1'($urandom), "rand");
      end

      rand_img(255);
      run_frame(16'd255, 1'b1, "cnt255");

      // Reset while word index 2 of a 5-word frame is strobing
      rand_img(5);
      b_log  = log_q.size();
      b_done = dones;
      send(8'hA5, 1'b0);
      send(8'h00, 1'b0);
      send(8'h05, 1'b0);
      for (int i = 0; i < 3; i++) begin
         send(img[i][15:8], 1'b0);
         send(img[i][7:0], i == 2);
      end
      bus.rx_valid = 1'b0;
      chk("t5 pre-reset pg_wr", bus.pg_wr, 1);
      #1 rst = 1'b1;
      #1 chk("t5 async drop", {bus.pg_wr, bus.pgm, bus.busy, bus.cpu_hold}, 0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      check_writes("t5", b_log, 2);
      chk("t5 no done", dones - b_done, 0);

      rand_img(6);
      run_frame(16'd6, 1'b0, "t5 reload");
      chk("final no rx_ready in write", viol, 0);
      chk("final strobe hi", {16'(hi_min), 16'(hi_max)}, {16'd4, 16'd4});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
